// File: rtl/pkt_run_checker.sv
// Multi-packet run controller for polar_decoder regression: loads each pattern,
// runs the decoder under a watchdog, then compares the DEC memory against golden.
module pkt_run_checker #(
  parameter int NUM_PACK  = 17,
  parameter int DEC_WIDTH = 140,
  parameter int DEC_ADDRW = 6,
  parameter int MAX_CYC   = 1000000,
  parameter int CYC_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_load_req,
  input  logic                 i_load_ack,
  output logic [5:0]           o_pack_idx,
  input  logic [5:0]           i_pack_num,
  output logic                 o_module_en,
  input  logic                 i_proc_done,
  output logic [DEC_ADDRW-1:0] o_chk_addr,
  input  logic [DEC_WIDTH-1:0] i_dec_rdata,
  input  logic [DEC_WIDTH-1:0] i_gold_rdata,
  output logic [11:0]          o_pass_cnt,
  output logic [11:0]          o_err_cnt,
  output logic [5:0]           o_timeout_cnt,
  output logic [CYC_W-1:0]     o_last_cyc,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CHECK = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FIN   = 3'd6
  } state_e;

  localparam logic [CYC_W-1:0] MAX_CYC_C  = CYC_W'(MAX_CYC);
  localparam logic [5:0]       LAST_IDX_C = 6'(NUM_PACK - 1);

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  state_e               state_q, state_d;
  logic [5:0]           pack_idx_q, pack_idx_d;
  logic [5:0]           npack_q, npack_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [CYC_W-1:0]     last_cyc_q, last_cyc_d;
  logic [6:0]           chk_cnt_q, chk_cnt_d;
  logic [DEC_ADDRW-1:0] chk_addr_q, chk_addr_d;
  logic [11:0]          pass_q, pass_d;
  logic [11:0]          err_q, err_d;
  logic [5:0]           tmo_q, tmo_d;
  logic                 load_req_q, load_req_d;
  logic                 module_en_q, module_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 words_differ_s;
  logic [6:0]           chk_nxt_s;

  assign words_differ_s = (i_dec_rdata != i_gold_rdata);
  assign chk_nxt_s      = chk_cnt_q + 7'd1;

  // Next-state, counters and datapath; outputs are decoded from the next state.
  always_comb begin
    state_d    = state_q;
    pack_idx_d = pack_idx_q;
    npack_d    = npack_q;
    cyc_d      = cyc_q;
    last_cyc_d = last_cyc_q;
    chk_cnt_d  = chk_cnt_q;
    chk_addr_d = chk_addr_q;
    pass_d     = pass_q;
    err_d      = err_q;
    tmo_d      = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_LOAD;
          pass_d     = 12'd0;
          err_d      = 12'd0;
          tmo_d      = 6'd0;
          pack_idx_d = 6'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_load_ack) begin
          npack_d = i_pack_num;
          cyc_d   = {{(CYC_W-1){1'b0}}, 1'b1};
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        // A completion on the watchdog's final cycle still counts as a good run.
        if (i_proc_done) begin
          last_cyc_d = cyc_q;
          state_d    = ST_DRAIN;
        end else if (cyc_q >= MAX_CYC_C) begin
          tmo_d      = sat_inc6(tmo_q);
          last_cyc_d = MAX_CYC_C;
          state_d    = ST_NEXT;
        end else begin
          cyc_d = cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DRAIN: begin
        chk_cnt_d  = 7'd0;
        chk_addr_d = {DEC_ADDRW{1'b0}};
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        // Read data trails the address by one cycle, so cycle N compares word N-1.
        if (chk_cnt_q != 7'd0) begin
          if (words_differ_s) begin
            err_d = sat_inc12(err_q);
          end else begin
            pass_d = sat_inc12(pass_q);
          end
        end else begin
          err_d = err_q;
        end
        if (chk_cnt_q == {1'b0, npack_q}) begin
          state_d = ST_NEXT;
        end else begin
          chk_cnt_d = chk_nxt_s;
          if (chk_nxt_s < {1'b0, npack_q}) begin
            chk_addr_d = DEC_ADDRW'(chk_nxt_s);
          end else begin
            chk_addr_d = chk_addr_q;
          end
        end
      end
      ST_NEXT: begin
        if (pack_idx_q == LAST_IDX_C) begin
          state_d = ST_FIN;
        end else begin
          pack_idx_d = pack_idx_q + 6'd1;
          state_d    = ST_LOAD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    load_req_d  = (state_d == ST_LOAD);
    module_en_d = (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
  end

  // State and output registers; reset also drops the decoder enable immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pack_idx_q  <= 6'd0;
      npack_q     <= 6'd0;
      cyc_q       <= {CYC_W{1'b0}};
      last_cyc_q  <= {CYC_W{1'b0}};
      chk_cnt_q   <= 7'd0;
      chk_addr_q  <= {DEC_ADDRW{1'b0}};
      pass_q      <= 12'd0;
      err_q       <= 12'd0;
      tmo_q       <= 6'd0;
      load_req_q  <= 1'b0;
      module_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pack_idx_q  <= pack_idx_d;
      npack_q     <= npack_d;
      cyc_q       <= cyc_d;
      last_cyc_q  <= last_cyc_d;
      chk_cnt_q   <= chk_cnt_d;
      chk_addr_q  <= chk_addr_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      load_req_q  <= load_req_d;
      module_en_q <= module_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_load_req    = load_req_q;
  assign o_pack_idx    = pack_idx_q;
  assign o_module_en   = module_en_q;
  assign o_chk_addr    = chk_addr_q;
  assign o_pass_cnt    = pass_q;
  assign o_err_cnt     = err_q;
  assign o_timeout_cnt = tmo_q;
  assign o_last_cyc    = last_cyc_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule
